seg7_scan_capture: RTL
======================

Name: seg7_scan_capture

Overview:
- Receive end of the multiplexed two-digit seven-segment display interface.
- Samples the segment bus and the two digit strobes, then decodes the segment patterns back to BCD.
- Filters the scan for stability, infers tens-digit blanking, and presents the displayed two-digit value with valid, update and error flags.
- Used as an on-chip loopback monitor and as a self-checking capture block for display-driving designs.

Parameters:
- STABLE_CNT, 4: consecutive identical decoded samples required before a digit is committed (≥2).
- TENS_TO, 64: active ones-digit samples with no tens strobe after which tens is committed as 0 (blanked-zero rule).
- IDLE_TO, 256: consecutive cycles with no strobe active after which the display is considered blank.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: asynchronous active-low reset.
- seg_in, input, 7: segments; bit0=a … bit6=g.
- strobe_in, input, 2: bit0 = ones-digit select, bit1 = tens-digit select.
- cfg_anode, input, 1:
  - 0: segments active-high, strobes active-low.
  - 1: segments active-low, strobes active-high.
- err_clr, input, 1: synchronous clear of seg_err.
- digit1, output, 4: committed ones digit.
- digit10, output, 4: committed tens digit.
- value_valid, output, 1: high while a locked value is displayed.
- update, output, 1: one-cycle pulse when the committed value changes or lock is gained.
- blank, output, 1: display idle (no strobes).
- seg_err, output, 1: sticky error flag.

Behaviour:
- **Reset values:** async reset clears everything. digit1=0, digit10=0, value_valid=0, update=0, blank=1, seg_err=0, FSM=S_BLANK, all filter and timeout counters 0.
- **Input sync:** seg_in, strobe_in and cfg_anode pass through a 2-flop synchronizer. All decisions use stage-2 values, so latency from pin to sample is 2 cycles.
- **Normalisation:**
  - seg = cfg_anode ? ~seg_s : seg_s.
  - act[i] = cfg_anode ? strobe_s[i] : ~strobe_s[i].
- **Sample class (per cycle):**
  - ONES when act=01.
  - TENS when act=10.
  - IDLE when act=00.
  - CONFLICT when act=11: sets seg_err and is otherwise ignored. It does not count as idle.
- **Decode:**
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - Any other pattern in a ONES/TENS sample: sets seg_err; the sample is discarded and leaves filter state untouched.
- **Stability filter (one per position):**
  - Decoded == candidate: counter increments, saturating at STABLE_CNT.
  - Otherwise: candidate = decoded, counter = 1.
  - Commit happens on the cycle the counter reaches STABLE_CNT: digitN <= candidate, visible the next cycle.
- **Tens blanking:**
  - Tens-absence counter increments on each ONES sample and resets on each TENS sample.
  - On reaching TENS_TO it commits digit10=0, then holds until the next TENS sample.
- **Idle counter:** increments on IDLE samples, resets on any ONES, TENS or CONFLICT sample, saturates at IDLE_TO.
- **FSM:**
  - S_BLANK: blank=1, value_valid=0. Any ONES/TENS sample → S_ACQ, and both filters are cleared.
  - S_ACQ: blank=0. First ones commit → S_LOCKED, with value_valid=1 and update pulsed. Idle counter = IDLE_TO → S_BLANK.
  - S_LOCKED: a commit that changes digit1 or digit10 pulses update. Idle counter = IDLE_TO → S_BLANK with value_valid=0; digits hold their last values.
- **Simultaneous events:**
  - Ones and tens commits in the same cycle produce a single update pulse.
  - If err_clr and a new error coincide, seg_err stays 1 (set wins).
  - Recommitting an identical value produces no update.
- **Reset mid-operation:** immediate async return to reset values. The filters need STABLE_CNT fresh samples before any commit.

Optional Feature:
- Macro: SEG7CAP_HEX_EN.
- Defined: additionally decodes 0x77→A, 0x7C→b, 0x39→C, 0x5E→d, 0x79→E, 0x71→F as 10–15. The tens rule is unchanged.
- Undefined: these patterns are invalid and set seg_err.

Test Plan:
- cfg_anode=0; alternate ONES seg=0x66 and TENS seg=0x06 every cycle for 20 cycles → digit10=1, digit1=4, value_valid=1, exactly one update pulse, blank=0.
- After lock, ones changes 4→3 (0x4F) for 8 ONES samples → digit1=3 after the 4th ONES sample (+2 sync +1), one update pulse, digit10 stays 1.
- ONES seg=0x5B only, no tens strobe, for 70 cycles → digit1=2, digit10=0 after 64 ONES samples; value_valid=1.
- Hold act=00 for 256 cycles while locked → blank=1, value_valid=0, digits hold; the next ONES sample returns FSM to S_ACQ.
- Inject seg=0x77 on ONES → seg_err=1 when SEG7CAP_HEX_EN is undefined (digit1 unchanged); with the macro defined, digit1=10 after STABLE_CNT samples. Assert err_clr → seg_err=0.
- cfg_anode=1 with inverted stimulus of the first scenario → identical outputs. act=11 for one cycle → seg_err=1, no commit. Pulse rst_n low mid-scan → all outputs at reset values immediately.

Source files
------------

// File: rtl/seg7cap_if.sv
// seg7cap_if: pin bundle between a scanned 7-seg display bus and
// seg7_scan_capture; master drives the display pins, slave captures.
interface seg7cap_if;
  logic [6:0] seg_in;
  logic [1:0] strobe_in;
  logic       cfg_anode;
  logic       err_clr;
  logic [3:0] digit1;
  logic [3:0] digit10;
  logic       value_valid;
  logic       update;
  logic       blank;
  logic       seg_err;

  modport master (
    output seg_in, strobe_in, cfg_anode, err_clr,
    input  digit1, digit10, value_valid,
    input  update, blank, seg_err
  );

  modport slave (
    input  seg_in, strobe_in, cfg_anode, err_clr,
    output digit1, digit10, value_valid,
    output update, blank, seg_err
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: decodes a scanned 2-digit 7-seg bus back to BCD.
// Define SEG7CAP_HEX_EN to also accept hex digit patterns A-F.
module seg7_scan_capture #(
  parameter int STABLE_CNT = 4,
  parameter int TENS_TO    = 64,
  parameter int IDLE_TO    = 256
) (
  input logic      clk,
  input logic      rst_n,
  seg7cap_if.slave bus
);
  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam int TW = $clog2(TENS_TO + 1);
  localparam int IW = $clog2(IDLE_TO + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STABLE_CNT);
  localparam logic [SW-1:0] S_PRE = SW'(STABLE_CNT - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TENS_TO);
  localparam logic [TW-1:0] T_PRE = TW'(TENS_TO - 1);
  localparam logic [IW-1:0] I_MAX = IW'(IDLE_TO);

  typedef enum logic [1:0] {
    S_BLANK,
    S_ACQ,
    S_LOCKED
  } state_t;

  function automatic logic [4:0] f_dec(input logic [6:0] s);
    logic [4:0] d;
    case (s)
      7'h3F:   d = 5'h10;
      7'h06:   d = 5'h11;
      7'h5B:   d = 5'h12;
      7'h4F:   d = 5'h13;
      7'h66:   d = 5'h14;
      7'h6D:   d = 5'h15;
      7'h7D:   d = 5'h16;
      7'h07:   d = 5'h17;
      7'h7F:   d = 5'h18;
      7'h6F:   d = 5'h19;
`ifdef SEG7CAP_HEX_EN
      7'h77:   d = 5'h1A;
      7'h7C:   d = 5'h1B;
      7'h39:   d = 5'h1C;
      7'h5E:   d = 5'h1D;
      7'h79:   d = 5'h1E;
      7'h71:   d = 5'h1F;
`endif
      default: d = 5'h00;
    endcase
    return d;
  endfunction

  logic [6:0]    r_seg_s1, r_seg_s2;
  logic [1:0]    r_stb_s1, r_stb_s2;
  logic          r_cfg_s1, r_cfg_s2;
  logic [3:0]    r_cand1, r_cand10;
  logic [SW-1:0] r_cnt1, r_cnt10;
  logic [TW-1:0] r_tabs;
  logic [IW-1:0] r_idle;
  state_t        r_state;
  logic [3:0]    r_digit1, r_digit10;
  logic          r_valid, r_update, r_blank, r_err;

  logic [6:0] w_seg;
  logic [1:0] w_act;
  logic       w_ones, w_tens, w_idle, w_conf;
  logic       w_ok;
  logic [3:0] w_dec;
  logic       w_g1, w_g10, w_run;
  logic       w_com1, w_com10, w_tblk;
  logic       w_idle_to, w_chg, w_err_set;

  // Strobe syncs reset to 2'b11 so the idle pipeline reads as no-strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= '0;
      r_seg_s2 <= '0;
      r_stb_s1 <= 2'b11;
      r_stb_s2 <= 2'b11;
      r_cfg_s1 <= 1'b0;
      r_cfg_s2 <= 1'b0;
    end else begin
      r_seg_s1 <= bus.seg_in;
      r_seg_s2 <= r_seg_s1;
      r_stb_s1 <= bus.strobe_in;
      r_stb_s2 <= r_stb_s1;
      r_cfg_s1 <= bus.cfg_anode;
      r_cfg_s2 <= r_cfg_s1;
    end
  end

  assign w_seg  = r_cfg_s2 ? ~r_seg_s2 : r_seg_s2;
  assign w_act  = r_cfg_s2 ? r_stb_s2 : ~r_stb_s2;
  assign w_ones = (w_act == 2'b01);
  assign w_tens = (w_act == 2'b10);
  assign w_idle = (w_act == 2'b00);
  assign w_conf = (w_act == 2'b11);

  assign {w_ok, w_dec} = f_dec(w_seg);

  assign w_g1      = w_ones && w_ok;
  assign w_g10     = w_tens && w_ok;
  assign w_run     = (r_state != S_BLANK);
  assign w_com1    = w_run && w_g1 && (w_dec == r_cand1)
                   && (r_cnt1 == S_PRE);
  assign w_com10   = w_run && w_g10 && (w_dec == r_cand10)
                   && (r_cnt10 == S_PRE);
  assign w_tblk    = w_run && w_ones && (r_tabs == T_PRE);
  assign w_idle_to = (r_idle == I_MAX);
  assign w_err_set = w_conf || ((w_ones || w_tens) && !w_ok);
  assign w_chg     = (w_com1 && (r_cand1 != r_digit1))
                   || (w_com10 && (r_cand10 != r_digit10))
                   || (w_tblk && (r_digit10 != 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand1  <= '0;
      r_cand10 <= '0;
      r_cnt1   <= '0;
      r_cnt10  <= '0;
      r_tabs   <= '0;
      r_idle   <= '0;
    end else begin
      if (!w_run) begin
        // Leaving blank restarts both filters from this sample.
        if (w_ones || w_tens) begin
          r_cand1  <= w_dec;
          r_cnt1   <= SW'(w_g1);
          r_cand10 <= w_dec;
          r_cnt10  <= SW'(w_g10);
        end
      end else begin
        if (w_g1) begin
          if (w_dec == r_cand1) begin
            if (r_cnt1 != S_MAX) r_cnt1 <= r_cnt1 + SW'(1);
          end else begin
            r_cand1 <= w_dec;
            r_cnt1  <= SW'(1);
          end
        end
        if (w_g10) begin
          if (w_dec == r_cand10) begin
            if (r_cnt10 != S_MAX) r_cnt10 <= r_cnt10 + SW'(1);
          end else begin
            r_cand10 <= w_dec;
            r_cnt10  <= SW'(1);
          end
        end
      end
      if (w_tens) r_tabs <= '0;
      else if (w_ones && r_tabs != T_MAX) r_tabs <= r_tabs + TW'(1);
      if (!w_idle) r_idle <= '0;
      else if (r_idle != I_MAX) r_idle <= r_idle + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_BLANK;
      r_digit1  <= '0;
      r_digit10 <= '0;
      r_valid   <= 1'b0;
      r_update  <= 1'b0;
      r_blank   <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (w_err_set) r_err <= 1'b1;
      else if (bus.err_clr) r_err <= 1'b0;
      if (w_com1) r_digit1 <= r_cand1;
      if (w_com10) r_digit10 <= r_cand10;
      else if (w_tblk) r_digit10 <= 4'd0;
      unique case (r_state)
        S_BLANK: begin
          if (w_ones || w_tens) begin
            r_state <= S_ACQ;
            r_blank <= 1'b0;
          end
        end
        S_ACQ: begin
          if (w_idle_to) begin
            r_state <= S_BLANK;
            r_blank <= 1'b1;
          end else if (w_com1) begin
            r_state  <= S_LOCKED;
            r_valid  <= 1'b1;
            r_update <= 1'b1;
          end
        end
        S_LOCKED: begin
          if (w_idle_to) begin
            r_state <= S_BLANK;
            r_blank <= 1'b1;
            r_valid <= 1'b0;
          end else if (w_chg) begin
            r_update <= 1'b1;
          end
        end
        default: r_state <= S_BLANK;
      endcase
    end
  end

  assign bus.digit1      = r_digit1;
  assign bus.digit10     = r_digit10;
  assign bus.value_valid = r_valid;
  assign bus.update      = r_update;
  assign bus.blank       = r_blank;
  assign bus.seg_err     = r_err;
endmodule
